// File: rtl/reg_dump_reader_pkg.sv
// Shared types and constants for the register dump reader.
// REG_DUMP_SKIP_ZERO_EN selects whether the walk skips hardwired register 0.
package reg_dump_reader_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRead = 2'd1,
    StWait = 2'd2,
    StDone = 2'd3
  } state_e;

  localparam int unsigned NUM_REGS_DEF = 32;
  localparam int unsigned ADDR_W_DEF   = 5;
  localparam int unsigned DATA_W_DEF   = 32;

`ifdef REG_DUMP_SKIP_ZERO_EN
  localparam int unsigned FIRST_IDX = 1;
`else
  localparam int unsigned FIRST_IDX = 0;
`endif

endpackage

// File: rtl/reg_dump_reader_dump_idx_counter.sv
// Register index counter for the dump walk: clear, load of the first index,
// increment, and a flag marking the last register.
module dump_idx_counter #(
  parameter int unsigned ADDR_W    = 5,
  parameter int unsigned NUM_REGS  = 32,
  parameter int unsigned FIRST_IDX = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              load,
  input  logic              inc,
  output logic [ADDR_W-1:0] idx,
  output logic              last
);

  assign last = (idx == ADDR_W'(NUM_REGS - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      idx <= '0;
    end else if (clr) begin
      idx <= '0;
    end else if (load) begin
      idx <= ADDR_W'(FIRST_IDX);
    end else if (inc && !last) begin
      // Saturating at the last index keeps out_idx inside the register range.
      idx <= idx + 1'b1;
    end
  end

endmodule

// File: rtl/reg_dump_reader.sv
// Walks the register file read port and streams each value over valid/ready.
// Build option REG_DUMP_SKIP_ZERO_EN starts the walk at register 1.
module reg_dump_reader
  import reg_dump_reader_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned NUM_REGS = NUM_REGS_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_idx,
  output logic              busy,
  output logic              done
);

  state_e            state_q;
  logic [ADDR_W-1:0] idx;
  logic              last;
  logic              cnt_clr;
  logic              cnt_load;
  logic              cnt_inc;

  always_comb begin
    cnt_load = (state_q == StIdle) && start && !abort;
    cnt_clr  = ((state_q != StIdle) && abort) || (state_q == StDone);
    cnt_inc  = (state_q == StWait) && out_valid && out_ready && !abort && !last;
  end

  dump_idx_counter #(
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS),
    .FIRST_IDX(FIRST_IDX)
  ) u_idx_counter (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .load(cnt_load),
    .inc (cnt_inc),
    .idx (idx),
    .last(last)
  );

  assign rd_addr = idx;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StIdle;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start && !abort) begin
            state_q <= StRead;
            busy    <= 1'b1;
          end
        end
        StRead: begin
          if (abort) begin
            state_q <= StIdle;
            busy    <= 1'b0;
          end else begin
            // Snapshot here; later writes to this register do not reach the sink.
            out_data  <= rd_data;
            out_idx   <= idx;
            out_valid <= 1'b1;
            state_q   <= StWait;
          end
        end
        StWait: begin
          if (abort) begin
            state_q   <= StIdle;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            if (last) begin
              state_q <= StDone;
              done    <= 1'b1;
            end else begin
              state_q <= StRead;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_dump_reader.sv
// Self-checking bench for reg_dump_reader: a cycle table plus directed dump,
// backpressure, coherency, abort and reset sequences.
module tb_reg_dump_reader;

`ifdef REG_DUMP_SKIP_ZERO_EN
  localparam int FIRST = 1;
`else
  localparam int FIRST = 0;
`endif
  localparam int NWORDS = 32 - FIRST;

  logic        clk;
  logic        rst;
  logic        start;
  logic        abort;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_idx;
  logic        busy;
  logic        done;

  logic [31:0] reg_file [32];

  int passed;
  int total;

  assign rd_data = reg_file[rd_addr];

  reg_dump_reader dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_idx  (out_idx),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       start;
    logic       abort;
    logic       ready;
    logic       exp_valid;
    logic       exp_busy;
    logic       exp_done;
    logic [4:0] exp_addr;
    logic [4:0] exp_oidx;
  } vec_t;

  vec_t vecs [9];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: actual=%h required=%h", name, act, exp);
  endtask

  task automatic preload();
    for (int k = 0; k < 32; k++) reg_file[k] = 32'hA5A50000 + k;
  endtask

  function automatic logic [31:0] exp_word(input int k);
    return (k == 20) ? 32'h12345678 : 32'hA5A50000 + k;
  endfunction

  initial begin
    int cyc;
    int words;
    bit seen_done;
    bit found;
    bit done_seen_after_abort;

    passed = 0;
    total  = 0;
    preload();

    //              start abort ready valid busy done addr            oidx
    vecs[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0,           5'd0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'(FIRST),      5'd0};
    vecs[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'(FIRST),      5'(FIRST)};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'(FIRST),      5'(FIRST)};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'(FIRST + 1),  5'd0};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5'(FIRST + 1),  5'(FIRST + 1)};
    vecs[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0,           5'd0};
    vecs[7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'(FIRST),      5'd0};
    vecs[8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0,           5'd0};

    // Reset, with start held high to confirm it is ignored.
    rst = 1'b0; start = 1'b1; abort = 1'b0; out_ready = 1'b0;
    step();
    step();
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_addr", rd_addr, 0);
    check("rst_oidx", out_idx, 0);
    check("rst_odata", out_data, 0);
    rst = 1'b1; start = 1'b0;
    step();
    check("rst_release_busy", busy, 0);

    for (int i = 0; i < 9; i++) begin
      start = vecs[i].start; abort = vecs[i].abort; out_ready = vecs[i].ready;
      step();
      check($sformatf("vec%0d_valid", i), out_valid, vecs[i].exp_valid);
      check($sformatf("vec%0d_busy", i), busy, vecs[i].exp_busy);
      check($sformatf("vec%0d_done", i), done, vecs[i].exp_done);
      check($sformatf("vec%0d_addr", i), rd_addr, vecs[i].exp_addr);
      if (vecs[i].exp_valid) begin
        check($sformatf("vec%0d_oidx", i), out_idx, vecs[i].exp_oidx);
        check($sformatf("vec%0d_data", i), out_data, 32'hA5A50000 + vecs[i].exp_oidx);
      end
    end
    start = 1'b0; abort = 1'b0;

    // Full dump with out_ready high; start poked while busy; coherency writes at idx 7.
    out_ready = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    cyc = 1; words = 0; seen_done = 0;
    for (int n = 0; n < 200 && !seen_done; n++) begin
      if (done) begin
        seen_done = 1;
      end else begin
        if (out_valid) begin
          check("dump_idx", out_idx, FIRST + words);
          check("dump_data", out_data, exp_word(FIRST + words));
          if (out_idx == 5'd7) begin
            reg_file[7]  = 32'hDEADBEEF;
            reg_file[20] = 32'h12345678;
            #1;
            check("coherent_hold", out_data, 32'hA5A50007);
          end
          words++;
        end
        start = (n % 3 == 0);
        step();
        cyc++;
      end
    end
    check("dump_done_seen", seen_done, 1);
    check("dump_cycles", cyc - 1, 2 * NWORDS);
    check("dump_words", words, NWORDS);
    check("busy_in_done", busy, 1);
    start = 1'b1;
    step();
    check("busy_after_done", busy, 0);
    check("done_one_cycle", done, 0);
    start = 1'b0;
    step();
    check("start_in_done_ignored", busy, 0);
    preload();

    // Backpressure at idx 3.
    out_ready = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    found = 0;
    for (int n = 0; n < 100 && !found; n++) begin
      if (busy && !out_valid && rd_addr == 5'd3) begin
        out_ready = 1'b0;
        found = 1;
      end else begin
        step();
      end
    end
    check("bp_reach_idx3", found, 1);
    step();
    for (int i = 0; i < 5; i++) begin
      check("bp_hold_valid", out_valid, 1);
      check("bp_hold_idx", out_idx, 3);
      check("bp_hold_data", out_data, 32'hA5A50003);
      step();
    end
    out_ready = 1'b1;
    step();
    check("bp_release_read", out_valid, 0);
    step();
    check("bp_idx4_valid", out_valid, 1);
    check("bp_idx4_idx", out_idx, 4);
    check("bp_idx4_data", out_data, 32'hA5A50004);

    // Abort in WAIT at idx 10, with out_ready also high.
    found = 0;
    for (int n = 0; n < 100 && !found; n++) begin
      if (out_valid && out_idx == 5'd10) found = 1;
      else step();
    end
    check("abort_reach_idx10", found, 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_addr", rd_addr, 0);
    done_seen_after_abort = done;
    for (int i = 0; i < 3; i++) begin
      step();
      done_seen_after_abort |= done;
    end
    check("abort_no_done", done_seen_after_abort, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    check("restart_valid", out_valid, 1);
    check("restart_idx", out_idx, FIRST);

    // Reset mid-dump at idx 15 with start asserted.
    found = 0;
    for (int n = 0; n < 100 && !found; n++) begin
      if (out_valid && out_idx == 5'd15) found = 1;
      else step();
    end
    check("rst_reach_idx15", found, 1);
    rst = 1'b0; start = 1'b1;
    step();
    check("midrst_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_addr", rd_addr, 0);
    check("midrst_oidx", out_idx, 0);
    check("midrst_odata", out_data, 0);
    rst = 1'b1; start = 1'b0;
    step();
    check("midrst_start_ignored", busy, 0);
    check("midrst_addr_idle", rd_addr, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/reg_dump_reader.md
Name: reg_dump_reader

Overview:
- Read-side companion to the 32-bit register group; drives the register file read port to walk all registers in sequence.
- Streams each value out over a valid/ready handshake for debug dump and checkpoint verification.
- Sits between the register file read port and the debug/trace sink.
- One dump per start pulse; busy while running; one-cycle done pulse at the end.

Parameters:
- DATA_W, 32, register width in bits.
- NUM_REGS, 32, number of registers walked.
- ADDR_W, 5, register index width; must satisfy 2^ADDR_W >= NUM_REGS.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous active-low reset; rst==0 at a rising edge resets the block.
- start  input  1  begin dump; sampled only in IDLE.
- abort  input  1  synchronous abort of a running dump.
- rd_addr  output  ADDR_W  register file read address (combinational read port).
- rd_data  input  DATA_W  register file read data; valid in the same cycle as rd_addr.
- out_valid  output  1  out_data/out_idx hold a captured register.
- out_ready  input  1  sink accepts the current word.
- out_data  output  DATA_W  captured register value.
- out_idx  output  ADDR_W  index of the captured register.
- busy  output  1  high in READ, WAIT and DONE.
- done  output  1  one-cycle pulse in DONE.

Behaviour:
- Reset (rst==0 at edge): state=IDLE, idx=0, rd_addr=0, out_valid=0, out_data=0, out_idx=0, busy=0, done=0.
- FSM states: IDLE, READ, WAIT, DONE.
- IDLE:
  - start=1 and abort=0 -> READ with idx=first index (0).
  - abort wins over a simultaneous start; the block stays in IDLE.
- READ:
  - rd_addr=idx.
  - Next edge: out_data<=rd_data, out_idx<=idx, out_valid<=1, state -> WAIT.
- WAIT:
  - out_valid=1; out_data/out_idx held stable until the handshake (out_valid & out_ready at an edge).
  - On handshake with idx==NUM_REGS-1: out_valid<=0, state -> DONE.
  - On handshake otherwise: idx<=idx+1, out_valid<=0, state -> READ.
  - No handshake: remain in WAIT; no limit on stall length.
- DONE: done=1 for exactly one cycle, then IDLE; idx returns to 0.
- Throughput and latency:
  - Throughput is one word per 2 cycles with out_ready held high.
  - With out_ready=1 throughout, a full dump takes 2*NUM_REGS cycles from the first READ to the DONE cycle.
  - First out_valid appears 2 edges after start is sampled.
- rd_addr holds idx in every state; it has no side effects on the register file.
- Coherency: each value is captured at the READ->WAIT edge. Later writes to that register do not change the held word. Writes to not-yet-read registers are reflected.
- start while busy is ignored, including in DONE.
- abort:
  - In READ, WAIT or DONE -> IDLE at the next edge, out_valid<=0, idx<=0.
  - done is not pulsed for an aborted dump; an in-flight word is dropped.
- Reset mid-dump: identical to the reset values above. out_valid drops at that edge regardless of out_ready.
- out_idx wraps nowhere: the counter never exceeds NUM_REGS-1.

Optional Feature:
- Macro: REG_DUMP_SKIP_ZERO_EN.
- Defined:
  - Register 0 is hardwired zero and is not dumped; the walk starts at index 1 and yields NUM_REGS-1 words.
  - Full dump takes 2*(NUM_REGS-1) cycles.
  - Reset and abort still set idx=0; idx is loaded to 1 on start.
- Undefined: all NUM_REGS registers are dumped, starting at index 0.

Decomposition:
- Shared package holds:
  - 2-bit state encoding: IDLE=2'd0, READ=2'd1, WAIT=2'd2, DONE=2'd3.
  - Constants NUM_REGS_DEF=32, ADDR_W_DEF=5, DATA_W_DEF=32.
  - First-index constant, selected by REG_DUMP_SKIP_ZERO_EN.
- One natural sub-module: dump_idx_counter, an ADDR_W-bit counter with synchronous active-low reset, load (first index), increment enable and last-index flag.
- FSM and output capture registers stay in the top module.

Test Plan:
- Full dump: preload reg k = 32'hA5A50000+k, out_ready=1, pulse start -> 32 words idx 0..31 with matching data, one word per 2 cycles; done pulses at cycle 64 after the first READ; busy drops the cycle after done.
- Backpressure: out_ready=0 for 5 cycles while idx=3 is valid -> out_data=32'hA5A50003 and out_idx=3 held stable; idx 4 appears 2 cycles after out_ready rises.
- Coherency: write reg 7=32'hDEADBEEF while idx 7 is in WAIT -> old value streamed. Write reg 20=32'h12345678 during idx 7 -> reg 20 streams 32'h12345678.
- Abort: abort at idx=10 in WAIT -> next cycle out_valid=0, busy=0, no done. A new start then dumps from idx 0.
- Reset mid-dump: rst=0 for one edge at idx=15 -> all outputs at reset values. start during that reset edge is ignored.
- Optional feature: with REG_DUMP_SKIP_ZERO_EN defined -> first out_idx=1 and 31 words, done after 62 cycles. start asserted with abort=1 in IDLE -> stays IDLE.
